// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encodings, field codes and the step-request record used by the
// stopwatch run/pause/adjust sequencer.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ADJ   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic FLD_SEC = 1'b0;
  localparam logic FLD_MIN = 1'b1;

  typedef struct packed {
    logic req;
    logic dn;
    logic fld;
  } step_req_t;

endpackage

// File: rtl/stopwatch_step_arb.sv
// Adjust-mode arbitration between the inc/dec buttons and the 2 Hz auto-repeat
// tick; yields at most one step request per cycle.
module stopwatch_step_arb
  import stopwatch_ctrl_pkg::*;
#(
  parameter bit ADJ_REPEAT = 1'b1
) (
  input  logic      tick_2hz_i,
  input  logic      btn_inc_i,
  input  logic      btn_dec_i,
  input  logic      sw_sel_i,
  input  logic      sw_adj_b_i,
  output step_req_t req_o
);

  logic any_btn;

  assign any_btn = btn_inc_i | btn_dec_i;

  // NOTE: every field gets a default first so no path leaves a latch behind.
  always_comb begin
    req_o = '0;
    if (btn_inc_i ^ btn_dec_i) begin
      req_o.req = 1'b1;
      req_o.dn  = btn_dec_i;
      req_o.fld = sw_sel_i;
    end else if (!any_btn && ADJ_REPEAT && tick_2hz_i) begin
      // Both buttons together still count as a press, so they also mask the tick.
      req_o.req = 1'b1;
      req_o.dn  = sw_adj_b_i;
      req_o.fld = sw_sel_i;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the stopwatch counter: turns button pulses,
// mode switches and divider ticks into registered step/clear commands and status.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter bit ADJ_REPEAT = 1'b1,
  parameter bit DONE_BLINK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       sw_adj,
  input  logic       sw_sel,
  input  logic       sw_adj_b,
  input  logic       sw_cnt_dn,
  input  logic       cnt_zero,
  output logic       step,
  output logic       step_dn,
  output logic       step_fld,
  output logic       clr,
  output logic       running,
  output logic       blink,
  output logic [2:0] state
);

  state_e    state_q, state_d;
  logic      step_q, step_d;
  logic      step_dn_q, step_dn_d;
  logic      step_fld_q, step_fld_d;
  logic      clr_q, clr_d;
  logic      running_q, running_d;
  logic      blink_q, blink_d;
  step_req_t adj_req;

  stopwatch_step_arb #(
    .ADJ_REPEAT(ADJ_REPEAT)
  ) u_step_arb (
    .tick_2hz_i(tick_2hz),
    .btn_inc_i (btn_inc),
    .btn_dec_i (btn_dec),
    .sw_sel_i  (sw_sel),
    .sw_adj_b_i(sw_adj_b),
    .req_o     (adj_req)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    step_dn_d  = 1'b0;
    step_fld_d = FLD_SEC;
    clr_d      = 1'b0;
    blink_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sw_adj)         state_d = ST_ADJ;
        else if (btn_pause) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sw_adj)         state_d = ST_ADJ;
        else if (btn_pause) state_d = ST_PAUSE;
        else if (tick_1hz) begin
          if (sw_cnt_dn && cnt_zero) begin
            state_d = ST_DONE;
            blink_d = !DONE_BLINK;
          end else begin
            step_d    = 1'b1;
            step_dn_d = sw_cnt_dn;
          end
        end
      end
      ST_PAUSE: begin
        if (sw_adj)         state_d = ST_ADJ;
        else if (btn_pause) state_d = ST_RUN;
      end
      ST_ADJ: begin
        if (!sw_adj) begin
          state_d = ST_PAUSE;
        end else begin
          step_d     = adj_req.req;
          step_dn_d  = adj_req.dn;
          step_fld_d = adj_req.fld;
          blink_d    = blink_q ^ tick_2hz;
        end
      end
      ST_DONE: begin
        if (sw_adj) begin
          state_d = ST_ADJ;
        end else if (btn_pause) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else begin
          blink_d = DONE_BLINK ? (blink_q ^ tick_2hz) : 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values together, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 1'b0;
      step_dn_q  <= 1'b0;
      step_fld_q <= FLD_SEC;
      clr_q      <= 1'b0;
      running_q  <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      step_dn_q  <= step_dn_d;
      step_fld_q <= step_fld_d;
      clr_q      <= clr_d;
      running_q  <= running_d;
      blink_q    <= blink_d;
    end
  end

  assign step     = step_q;
  assign step_dn  = step_dn_q;
  assign step_fld = step_fld_q;
  assign clr      = clr_q;
  assign running  = running_q;
  assign blink    = blink_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a cycle-by-cycle vector table plus a few
// hand-written timing sequences, all with hand-computed expectations.
module tb_stopwatch_ctrl;

  // Input bit positions, packed {rst,t1,t2,bp,bi,bd,adj,sel,adjb,cdn,cz}.
  localparam logic [10:0] R    = 11'h400;
  localparam logic [10:0] T1   = 11'h200;
  localparam logic [10:0] T2   = 11'h100;
  localparam logic [10:0] BP   = 11'h080;
  localparam logic [10:0] BI   = 11'h040;
  localparam logic [10:0] BD   = 11'h020;
  localparam logic [10:0] ADJ  = 11'h010;
  localparam logic [10:0] SEL  = 11'h008;
  localparam logic [10:0] ADJB = 11'h004;
  localparam logic [10:0] CDN  = 11'h002;
  localparam logic [10:0] CZ   = 11'h001;
  localparam logic [10:0] NONE = 11'h000;

  // Expected outputs packed {step,dn,fld,clr,running,blink,state[2:0]}.
  localparam logic [8:0] STEP = 9'h100;
  localparam logic [8:0] DN   = 9'h080;
  localparam logic [8:0] FLD  = 9'h040;
  localparam logic [8:0] CLR  = 9'h020;
  localparam logic [8:0] RUN  = 9'h010;
  localparam logic [8:0] BLK  = 9'h008;
  localparam logic [8:0] S_IDLE = 9'd0, S_RUN = 9'd1, S_PAUSE = 9'd2, S_ADJ = 9'd3, S_DONE = 9'd4;

  typedef struct {
    string       name;
    logic [10:0] in;
    logic [8:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1hz = 0, tick_2hz = 0, btn_pause = 0, btn_inc = 0, btn_dec = 0;
  logic sw_adj = 0, sw_sel = 0, sw_adj_b = 0, sw_cnt_dn = 0, cnt_zero = 0;
  logic step, step_dn, step_fld, clr, running, blink;
  logic [2:0] state;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .btn_pause(btn_pause),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .sw_adj   (sw_adj),
    .sw_sel   (sw_sel),
    .sw_adj_b (sw_adj_b),
    .sw_cnt_dn(sw_cnt_dn),
    .cnt_zero (cnt_zero),
    .step     (step),
    .step_dn  (step_dn),
    .step_fld (step_fld),
    .clr      (clr),
    .running  (running),
    .blink    (blink),
    .state    (state)
  );

  task automatic add(input string name, input logic [10:0] in, input logic [8:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {step, step_dn, step_fld, clr, running, blink, state};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {step,dn,fld,clr,run,blink,state}=%b required %b", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then compare 1 ns after the edge.
  task automatic cycle(input string name, input logic [10:0] in, input logic [8:0] exp);
    @(negedge clk);
    {rst, tick_1hz, tick_2hz, btn_pause, btn_inc, btn_dec,
     sw_adj, sw_sel, sw_adj_b, sw_cnt_dn, cnt_zero} = in;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    // Run, count up, pause/resume, direction change mid-run.
    add("reset",          R,              S_IDLE);
    add("start",          BP,             RUN | S_RUN);
    add("run_tick1",      T1,             STEP | RUN | S_RUN);
    add("run_gap",        NONE,           RUN | S_RUN);
    add("run_tick2",      T1,             STEP | RUN | S_RUN);
    add("run_2hz_ignored", T2,            RUN | S_RUN);
    add("pause",          BP,             S_PAUSE);
    add("pause_tick_a",   T1,             S_PAUSE);
    add("pause_tick_b",   T1 | T2,        S_PAUSE);
    add("pause_tick_c",   T1,             S_PAUSE);
    add("resume",         BP,             RUN | S_RUN);
    add("resume_tick1",   T1,             STEP | RUN | S_RUN);
    add("resume_tick2",   T1,             STEP | RUN | S_RUN);
    add("count_down",     T1 | CDN,       STEP | DN | RUN | S_RUN);
    add("dir_back_up",    T1,             STEP | RUN | S_RUN);
    add("up_from_zero",   T1 | CZ,        STEP | RUN | S_RUN);
    // Adjust mode: buttons, simultaneous buttons, button beats tick, auto-repeat.
    add("adj_enter",      ADJ | SEL,            S_ADJ);
    add("adj_inc_min",    ADJ | SEL | BI,       STEP | FLD | S_ADJ);
    add("adj_both_btn",   ADJ | SEL | BI | BD,  S_ADJ);
    add("adj_dec_tick",   ADJ | SEL | BD | T2,  STEP | DN | FLD | BLK | S_ADJ);
    add("adj_rep_up",     ADJ | SEL | T2,       STEP | FLD | S_ADJ);
    add("adj_rep_dn_sec", ADJ | T2 | ADJB,      STEP | DN | BLK | S_ADJ);
    add("adj_pause_ign",  ADJ | BP,             BLK | S_ADJ);
    add("adj_1hz_ign",    ADJ | T1,             BLK | S_ADJ);
    add("adj_release",    NONE,                 S_PAUSE);
    // Count down into DONE, blink, clear back to IDLE.
    add("to_run",         BP,             RUN | S_RUN);
    add("zero_hit",       T1 | CDN | CZ,  S_DONE);
    add("done_hold",      NONE,           S_DONE);
    add("done_blink1",    T2,             BLK | S_DONE);
    add("done_blink2",    T2,             S_DONE);
    add("done_blink3",    T2,             BLK | S_DONE);
    add("done_no_step",   T1 | CDN | CZ,  BLK | S_DONE);
    add("done_clear",     BP,             CLR | S_IDLE);
    add("clr_one_cycle",  NONE,           S_IDLE);
    // DONE -> ADJUST without clear.
    add("run_again",      BP,             RUN | S_RUN);
    add("zero_again",     T1 | CDN | CZ,  S_DONE);
    add("done_blink_b",   T2,             BLK | S_DONE);
    add("done_to_adj",    ADJ,            S_ADJ);
    add("adj_out",        NONE,           S_PAUSE);
    // Priority: sw_adj beats btn_pause and ticks; btn_pause beats tick.
    add("resume_b",       BP,             RUN | S_RUN);
    add("adj_over_pause", ADJ | BP,       S_ADJ);
    add("adj_out_b",      NONE,           S_PAUSE);
    add("resume_c",       BP,             RUN | S_RUN);
    add("adj_over_tick",  ADJ | T1,       S_ADJ);
    add("adj_out_c",      NONE,           S_PAUSE);
    add("resume_d",       BP,             RUN | S_RUN);
    add("pause_over_tick", BP | T1,       S_PAUSE);
    add("resume_e",       BP,             RUN | S_RUN);
    // Reset beats everything; IDLE ignores ticks and honours sw_adj.
    add("step_before_rst", T1,            STEP | RUN | S_RUN);
    add("rst_mid_step",   R | T1,         S_IDLE);
    add("rst_beats_all",  R | BP | ADJ | T1 | T2, S_IDLE);
    add("idle_tick_ign",  T1 | T2,        S_IDLE);
    add("idle_to_adj",    ADJ,            S_ADJ);
    add("final_reset",    R,              S_IDLE);

    foreach (vecs[k]) cycle(vecs[k].name, vecs[k].in, vecs[k].exp);

    // Sparse 1 Hz ticks: each step lands exactly one cycle after its tick.
    begin
      int steps_seen;
      steps_seen = 0;
      cycle("seq_start", BP, RUN | S_RUN);
      for (int t = 0; t < 5; t++) begin
        cycle($sformatf("seq_tick%0d", t), T1, STEP | RUN | S_RUN);
        if (step) steps_seen++;
        for (int g = 0; g < 3; g++) begin
          cycle($sformatf("seq_gap%0d_%0d", t, g), NONE, RUN | S_RUN);
          if (step) steps_seen++;
        end
      end
      n_vec++;
      if (steps_seen != 5) begin
        n_err++;
        $display("FAIL seq_step_count: got %0d steps required 5", steps_seen);
      end
    end

    // Reset raised together with a tick in RUN, then held low again.
    cycle("rst_tick_run", R | T1, S_IDLE);
    cycle("after_rst",    NONE,   S_IDLE);
    cycle("restart",      BP,     RUN | S_RUN);
    cycle("restart_tick", T1 | CDN, STEP | DN | RUN | S_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
